// File: rtl/store_align_buffer_if.sv
// Store-request and memory-write signals of the store align buffer.
interface store_align_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int NB = XLEN / 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            St_Valid;
  logic            St_Ready;
  logic [2:0]      St_Op;
  logic [XLEN-1:0] St_Addr;
  logic [XLEN-1:0] St_Data;
  logic            Flush;
  logic            Mem_Valid;
  logic            Mem_Ready;
  logic [XLEN-1:0] Mem_Addr;
  logic [XLEN-1:0] Mem_Wdata;
  logic [NB-1:0]   Mem_Wstrb;
  logic            St_Err;
  logic [CW-1:0]   Count;

  modport slave (
    input  St_Valid, St_Op, St_Addr, St_Data,
    input  Flush, Mem_Ready,
    output St_Ready, Mem_Valid, Mem_Addr,
    output Mem_Wdata, Mem_Wstrb, St_Err, Count
  );

  modport master (
    output St_Valid, St_Op, St_Addr, St_Data,
    output Flush, Mem_Ready,
    input  St_Ready, Mem_Valid, Mem_Addr,
    input  Mem_Wdata, Mem_Wstrb, St_Err, Count
  );
endinterface

// File: rtl/store_align_buffer.sv
// Store path: lane alignment, byte strobes, store queue and
// a beat-issue FSM that splits misaligned stores into two beats.
module store_align_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int SPLIT_MIS = 1
) (
  input  logic Clk,
  input  logic Reset_n,
  store_align_buffer_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [NB-1:0]   s0;
    logic [NB-1:0]   s1;
    logic            split;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic            err_q, err_d;

  ent_t ent_q [DEPTH];
  ent_t new_ent, head, nxt, src;

  logic [OFFW-1:0]   off;
  logic [3:0]        size;
  logic              legal, mis;
  logic              st_ready, acc, enq, pop;
  logic              load0, load1, go_next;
  logic [NB-1:0]     szmask;
  logic [XLEN-1:0]   data_m;
  logic [2*NB-1:0]   mask_w;
  logic [2*XLEN-1:0] data_w;

  always_comb begin
    legal = 1'b1;
    size  = 4'd1;
    case (bus.St_Op)
      3'b000: size = 4'd1;
      3'b001: size = 4'd2;
      3'b010: size = 4'd4;
      3'b011: begin
        size  = 4'd8;
        legal = (XLEN == 64);
      end
      default: legal = 1'b0;
    endcase
    for (int i = 0; i < NB; i++) begin
      szmask[i] = (i < int'(size));
      data_m[8*i +: 8] = szmask[i] ?
        bus.St_Data[8*i +: 8] : 8'h00;
    end
    off    = bus.St_Addr[OFFW-1:0];
    mask_w = {{NB{1'b0}}, szmask} << off;
    data_w = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
    mis    = |mask_w[2*NB-1:NB];
    new_ent.addr  = {bus.St_Addr[XLEN-1:OFFW],
                     {OFFW{1'b0}}};
    new_ent.d0    = data_w[XLEN-1:0];
    new_ent.d1    = data_w[2*XLEN-1:XLEN];
    new_ent.s0    = mask_w[NB-1:0];
    new_ent.s1    = mask_w[2*NB-1:NB];
    new_ent.split = mis;
  end

  assign st_ready = Reset_n && (count_q < CW'(DEPTH));
  assign acc      = bus.St_Valid && st_ready;
  assign enq      = acc && legal && !bus.Flush &&
                    (!mis || (SPLIT_MIS != 0));
  assign err_d    = acc &&
                    (!legal || (mis && (SPLIT_MIS == 0)));
  assign head     = ent_q[rd_ptr_q];
  assign nxt      = ent_q[rd_ptr_q + PW'(1)];

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    pop     = 1'b0;
    load0   = 1'b0;
    load1   = 1'b0;
    go_next = 1'b0;
    src     = head;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !bus.Flush) begin
          load0   = 1'b1;
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        if (bus.Mem_Ready) begin
          if (head.split) begin
            load1   = 1'b1;
            state_d = BEAT1;
          end else begin
            go_next = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus.Mem_Ready) go_next = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Chain straight into the next entry (or the one being
    // enqueued right now) so consecutive beats have no bubble.
    if (go_next) begin
      pop         = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
      state_d     = IDLE;
      mem_valid_d = 1'b0;
      if (!bus.Flush && count_q > CW'(1)) begin
        load0   = 1'b1;
        src     = nxt;
        state_d = BEAT0;
      end else if (enq) begin
        load0   = 1'b1;
        src     = new_ent;
        state_d = BEAT0;
      end
    end
    if (load0) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = src.addr;
      mem_wdata_d = src.d0;
      mem_wstrb_d = src.s0;
    end
    if (load1) begin
      mem_addr_d  = head.addr + XLEN'(NB);
      mem_wdata_d = head.d1;
      mem_wstrb_d = head.s1;
    end
    count_d = count_q + {{(CW-1){1'b0}}, enq}
                      - {{(CW-1){1'b0}}, pop};
    // Flush keeps only the entry whose beats are in flight.
    if (bus.Flush) begin
      if (state_q != IDLE && !pop) begin
        count_d  = CW'(1);
        wr_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        count_d  = '0;
        wr_ptr_d = rd_ptr_d;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (enq) ent_q[wr_ptr_q] <= new_ent;
  end

  assign bus.St_Ready  = st_ready;
  assign bus.Mem_Valid = mem_valid_q;
  assign bus.Mem_Addr  = mem_addr_q;
  assign bus.Mem_Wdata = mem_wdata_q;
  assign bus.Mem_Wstrb = mem_wstrb_q;
  assign bus.St_Err    = err_q;
  assign bus.Count     = count_q;
endmodule

// File: tb/tb_store_align_buffer.sv
// Scoreboard bench for store_align_buffer (XLEN=32, DEPTH=4),
// with a second instance built with SPLIT_MIS=0.
module tb_store_align_buffer;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t mb;
  bit    rnd_mode = 1'b0;
  bit    b_saw_valid = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_b;

  always #5 clk = ~clk;

  store_align_buffer_if #(.XLEN(32), .DEPTH(4)) bus_a ();
  store_align_buffer_if #(.XLEN(32), .DEPTH(4)) bus_b ();

  store_align_buffer #(.XLEN(32), .DEPTH(4), .SPLIT_MIS(1))
    dut_a (.Clk(clk), .Reset_n(rst_n), .bus(bus_a.slave));
  store_align_buffer #(.XLEN(32), .DEPTH(4), .SPLIT_MIS(0))
    dut_b (.Clk(clk), .Reset_n(rst_n), .bus(bus_b.slave));

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_beat(input logic [31:0] a,
                                    input logic [31:0] d,
                                    input logic [3:0] s);
    beat_t b;
    b.addr = a; b.data = d; b.strb = s;
    exp_q.push_back(b);
  endfunction

  // Byte-by-byte model: each byte lands in the word holding it.
  function automatic void push_store(input logic [2:0] op,
                                     input logic [31:0] addr,
                                     input logic [31:0] data);
    beat_t b0, b1;
    logic [31:0] a;
    int sz, lane;
    sz = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
    b0.addr = {addr[31:2], 2'b00};
    b1.addr = b0.addr + 32'd4;
    b0.data = '0; b0.strb = '0;
    b1.data = '0; b1.strb = '0;
    for (int k = 0; k < sz; k++) begin
      a = addr + k;
      lane = int'(a[1:0]);
      if (a[31:2] == b0.addr[31:2]) begin
        b0.data[8*lane +: 8] = data[8*k +: 8];
        b0.strb[lane] = 1'b1;
      end else begin
        b1.data[8*lane +: 8] = data[8*k +: 8];
        b1.strb[lane] = 1'b1;
      end
    end
    exp_q.push_back(b0);
    if (b1.strb != 4'd0) exp_q.push_back(b1);
  endfunction

  task automatic send(input logic [2:0] op,
                      input logic [31:0] addr,
                      input logic [31:0] data,
                      input bit model);
    int n;
    @(posedge clk); #1;
    bus_a.St_Valid = 1'b1;
    bus_a.St_Op = op;
    bus_a.St_Addr = addr;
    bus_a.St_Data = data;
    @(negedge clk);
    n = 0;
    while (!bus_a.St_Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.St_Ready) chk("st_ready_timeout", 0, 1);
    else if (model) push_store(op, addr, data);
    @(posedge clk); #1;
    bus_a.St_Valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_a.Mem_Valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.Mem_Valid) chk("mem_valid_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus_a.Count != 0
            || bus_a.Mem_Valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_left"}, 64'(exp_q.size()), 0);
    chk({tag, "_count"}, 64'(bus_a.Count), 0);
    chk({tag, "_idle"}, 64'(bus_a.Mem_Valid), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_a.Mem_Valid && bus_a.Mem_Ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        mb = exp_q.pop_front();
        chk("beat_addr", 64'(bus_a.Mem_Addr), 64'(mb.addr));
        chk("beat_wdata", 64'(bus_a.Mem_Wdata), 64'(mb.data));
        chk("beat_wstrb", 64'(bus_a.Mem_Wstrb), 64'(mb.strb));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("hold_valid", 64'(bus_a.Mem_Valid), 1);
      chk("hold_addr", 64'(bus_a.Mem_Addr), 64'(prev_b.addr));
      chk("hold_wdata", 64'(bus_a.Mem_Wdata), 64'(prev_b.data));
      chk("hold_wstrb", 64'(bus_a.Mem_Wstrb), 64'(prev_b.strb));
    end
    prev_stall = rst_n && bus_a.Mem_Valid && !bus_a.Mem_Ready;
    prev_b.addr = bus_a.Mem_Addr;
    prev_b.data = bus_a.Mem_Wdata;
    prev_b.strb = bus_a.Mem_Wstrb;
    if (rst_n && bus_b.Mem_Valid) b_saw_valid = 1'b1;
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      bus_a.Mem_Ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] first_addr;
    bus_a.St_Valid = 0; bus_a.St_Op = 0; bus_a.St_Addr = 0;
    bus_a.St_Data = 0; bus_a.Flush = 0; bus_a.Mem_Ready = 1;
    bus_b.St_Valid = 0; bus_b.St_Op = 0; bus_b.St_Addr = 0;
    bus_b.St_Data = 0; bus_b.Flush = 0; bus_b.Mem_Ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 64'(bus_a.Count), 0);
    chk("rst_valid", 64'(bus_a.Mem_Valid), 0);
    chk("rst_addr", 64'(bus_a.Mem_Addr), 0);
    chk("rst_wdata", 64'(bus_a.Mem_Wdata), 0);
    chk("rst_wstrb", 64'(bus_a.Mem_Wstrb), 0);
    chk("rst_err", 64'(bus_a.St_Err), 0);
    chk("rst_ready", 64'(bus_a.St_Ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SB with latency check
    send(3'b000, 32'h103, 32'h0000_00AB, 1'b0);
    push_beat(32'h100, 32'hAB00_0000, 4'b1000);
    @(negedge clk);
    chk("lat_before", 64'(bus_a.Mem_Valid), 0);
    @(negedge clk);
    chk("lat_after", 64'(bus_a.Mem_Valid), 1);
    drain("sb");

    // misaligned SW split in two beats
    send(3'b010, 32'h206, 32'h1122_3344, 1'b0);
    push_beat(32'h204, 32'h3344_0000, 4'b1100);
    push_beat(32'h208, 32'h0000_1122, 4'b0011);
    @(negedge clk);
    chk("split_no_err", 64'(bus_a.St_Err), 0);
    drain("split");

    // same store dropped by the SPLIT_MIS=0 instance
    @(posedge clk); #1;
    bus_b.St_Valid = 1; bus_b.St_Op = 3'b010;
    bus_b.St_Addr = 32'h206; bus_b.St_Data = 32'h1122_3344;
    @(negedge clk);
    chk("b_ready", 64'(bus_b.St_Ready), 1);
    @(posedge clk); #1;
    bus_b.St_Valid = 0;
    @(negedge clk);
    chk("b_err_pulse", 64'(bus_b.St_Err), 1);
    chk("b_count", 64'(bus_b.Count), 0);
    @(negedge clk);
    chk("b_err_drop", 64'(bus_b.St_Err), 0);
    repeat (3) @(negedge clk);
    chk("b_no_valid", 64'(b_saw_valid), 0);

    // fill the queue while memory stalls
    bus_a.Mem_Ready = 0;
    for (int i = 0; i < 4; i++)
      send(3'b010, 32'h300 + 32'(4*i), $urandom, 1'b1);
    @(negedge clk);
    chk("full_ready", 64'(bus_a.St_Ready), 0);
    chk("full_count", 64'(bus_a.Count), 4);
    @(posedge clk); #1;
    bus_a.Mem_Ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_bubble", 64'(bus_a.Mem_Valid), 1);
    end
    drain("fill");

    // flush with three queued; accept on flush edge discarded
    bus_a.Mem_Ready = 0;
    for (int i = 0; i < 3; i++)
      send(3'b010, 32'h500 + 32'(4*i), $urandom, 1'b1);
    wait_valid();
    first_addr = bus_a.Mem_Addr;
    chk("flush_head", 64'(first_addr), 64'h500);
    @(posedge clk); #1;
    bus_a.Flush = 1;
    bus_a.St_Valid = 1; bus_a.St_Op = 3'b010;
    bus_a.St_Addr = 32'h5F0; bus_a.St_Data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_a.Flush = 0;
    bus_a.St_Valid = 0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_count", 64'(bus_a.Count), 1);
    chk("flush_valid", 64'(bus_a.Mem_Valid), 1);
    chk("flush_addr", 64'(bus_a.Mem_Addr), 64'(first_addr));
    @(posedge clk); #1;
    bus_a.Mem_Ready = 1;
    drain("flush");

    // reset with beat1 pending
    bus_a.Mem_Ready = 0;
    send(3'b010, 32'h206, 32'hCAFE_F00D, 1'b1);
    wait_valid();
    @(posedge clk); #1;
    bus_a.Mem_Ready = 1;
    @(posedge clk); #1;
    bus_a.Mem_Ready = 0;
    @(negedge clk);
    chk("b1_valid", 64'(bus_a.Mem_Valid), 1);
    chk("b1_addr", 64'(bus_a.Mem_Addr), 64'h208);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus_a.Mem_Valid), 0);
    chk("mid_rst_count", 64'(bus_a.Count), 0);
    chk("mid_rst_ready", 64'(bus_a.St_Ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.Mem_Ready = 1;

    // illegal op
    send(3'b111, 32'h400, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("ill_err", 64'(bus_a.St_Err), 1);
    chk("ill_count", 64'(bus_a.Count), 0);
    @(negedge clk);
    chk("ill_err_drop", 64'(bus_a.St_Err), 0);
    chk("ill_no_valid", 64'(bus_a.Mem_Valid), 0);

    // random mix with random back-pressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 2)),
           32'h1000 + 32'($urandom_range(0, 255)),
           $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(negedge clk);
    rnd_mode = 1'b0;
    @(posedge clk); #2;
    bus_a.Mem_Ready = 1;
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
